// File: rtl/fft_pkg.sv
// Shared FFT package: default transform size and sample width, complex sample
// type, and the index bit-reversal helper used by the butterfly and reorder stages.
package fft_pkg;

  localparam int FFT_N = 3;
  localparam int FFT_W = 16;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  // Reverses the low n bits of idx; bits at and above n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int n);
    logic [31:0] r;
    logic [31:0] s;
    r = 32'd0;
    s = idx;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        r = {r[30:0], s[0]};
        s = {1'b0, s[31:1]};
      end else begin
        r = r;
        s = s;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store for the reorder buffer: one synchronous write port and
// one combinational read port, each addressed as {bank, idx}.
module fft_pingpong_ram #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW:0]   rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_r [2**(AW+1)];

  // Sample storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Re-emits bit-reversed FFT output frames in natural bin order via a ping-pong buffer.
// Defining FFT_REORDER_BYPASS_EN adds a per-frame bypass input that keeps arrival order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_real,
  input  logic signed [W-1:0] in_img,
`ifdef FFT_REORDER_BYPASS_EN
  input  logic                bypass,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_real,
  output logic signed [W-1:0] out_img,
  output logic [N-1:0]        out_idx,
  output logic                out_last
);

  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};

  logic                wr_bank_r;
  logic                rd_bank_r;
  logic                in_ready_r;
  logic [N-1:0]        wr_cnt_r;
  logic [N-1:0]        rd_cnt_r;
  logic [1:0]          bank_full_r;
  logic                out_valid_r;
  logic                out_last_r;
  logic signed [W-1:0] out_real_r;
  logic signed [W-1:0] out_img_r;
  logic [N-1:0]        out_idx_r;

  logic                wr_fire_s;
  logic                wr_wrap_s;
  logic                rd_load_s;
  logic                rd_wrap_s;
  logic                wr_bank_nxt_s;
  logic [1:0]          set_mask_s;
  logic [1:0]          clr_mask_s;
  logic [1:0]          bank_full_nxt_s;
  logic [N-1:0]        wr_rev_s;
  logic [N-1:0]        wr_idx_s;
  logic [2*W-1:0]      rd_data_s;

  assign wr_fire_s = in_valid & in_ready_r;
  assign wr_wrap_s = wr_fire_s & (wr_cnt_r == CNT_MAX);
  assign rd_load_s = (~out_valid_r | out_ready) & bank_full_r[rd_bank_r];
  assign rd_wrap_s = rd_load_s & (rd_cnt_r == CNT_MAX);
  assign wr_rev_s  = N'(bitrev(32'(wr_cnt_r), N));

`ifdef FFT_REORDER_BYPASS_EN
  logic [1:0] byp_bank_r;
  logic       byp_cur_s;

  // The first sample of a frame decides its mode; later samples reuse the bank flag
  always_comb begin
    byp_cur_s = byp_bank_r[wr_bank_r];
    if (wr_cnt_r == CNT_ZERO) begin
      byp_cur_s = bypass;
    end else begin
      byp_cur_s = byp_bank_r[wr_bank_r];
    end
    wr_idx_s = wr_rev_s;
    if (byp_cur_s) begin
      wr_idx_s = wr_cnt_r;
    end else begin
      wr_idx_s = wr_rev_s;
    end
  end

  // Per-bank bypass flag captured with the frame's first sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_bank_r <= 2'b00;
    end else if (wr_fire_s && (wr_cnt_r == CNT_ZERO)) begin
      byp_bank_r[wr_bank_r] <= bypass;
    end else begin
      byp_bank_r <= byp_bank_r;
    end
  end
`else
  // Every frame is scattered to its bit-reversed slot
  always_comb begin
    wr_idx_s = wr_rev_s;
  end
`endif

  // Next-state of full flags and write bank; set and clear never hit the same bank
  always_comb begin
    set_mask_s = 2'b00;
    clr_mask_s = 2'b00;
    if (wr_wrap_s) begin
      set_mask_s = {wr_bank_r, ~wr_bank_r};
    end else begin
      set_mask_s = 2'b00;
    end
    if (rd_wrap_s) begin
      clr_mask_s = {rd_bank_r, ~rd_bank_r};
    end else begin
      clr_mask_s = 2'b00;
    end
    bank_full_nxt_s = (bank_full_r | set_mask_s) & ~clr_mask_s;
    if (wr_wrap_s) begin
      wr_bank_nxt_s = ~wr_bank_r;
    end else begin
      wr_bank_nxt_s = wr_bank_r;
    end
  end

  // Write side: counter, bank pointer, full flags and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_r    <= CNT_ZERO;
      wr_bank_r   <= 1'b0;
      bank_full_r <= 2'b00;
      in_ready_r  <= 1'b1;
    end else begin
      bank_full_r <= bank_full_nxt_s;
      wr_bank_r   <= wr_bank_nxt_s;
      in_ready_r  <= ~bank_full_nxt_s[wr_bank_nxt_s];
      if (wr_fire_s) begin
        wr_cnt_r <= wr_cnt_r + CNT_ONE;
      end else begin
        wr_cnt_r <= wr_cnt_r;
      end
    end
  end

  // Read side: linear drain of the full bank into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_r    <= CNT_ZERO;
      rd_bank_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_real_r  <= {W{1'b0}};
      out_img_r   <= {W{1'b0}};
      out_idx_r   <= CNT_ZERO;
      out_last_r  <= 1'b0;
    end else if (rd_load_s) begin
      out_valid_r <= 1'b1;
      out_real_r  <= rd_data_s[2*W-1:W];
      out_img_r   <= rd_data_s[W-1:0];
      out_idx_r   <= rd_cnt_r;
      out_last_r  <= (rd_cnt_r == CNT_MAX);
      rd_cnt_r    <= rd_cnt_r + CNT_ONE;
      if (rd_wrap_s) begin
        rd_bank_r <= ~rd_bank_r;
      end else begin
        rd_bank_r <= rd_bank_r;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  fft_pingpong_ram #(
    .AW(N),
    .DW(2*W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire_s),
    .wr_addr ({wr_bank_r, wr_idx_s}),
    .wr_data ({in_real, in_img}),
    .rd_addr ({rd_bank_r, rd_cnt_r}),
    .rd_data (rd_data_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_real  = out_real_r;
  assign out_img   = out_img_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (N=3): frame-level model plus directed
// timing, back-pressure and reset cases; bypass case when FFT_REORDER_BYPASS_EN is set.
module tb_fft_bitrev_reorder;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int FL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_real;
  logic signed [W-1:0] in_img;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_real;
  logic signed [W-1:0] out_img;
  logic [N-1:0]        out_idx;
  logic                out_last;
`ifdef FFT_REORDER_BYPASS_EN
  logic                bypass;
`endif

  fft_bitrev_reorder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_img    (in_img),
`ifdef FFT_REORDER_BYPASS_EN
    .bypass    (bypass),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_img   (out_img),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  int br_tab [FL] = '{0, 4, 2, 6, 1, 5, 3, 7};

  typedef struct {
    int re;
    int im;
    int idx;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   arr_re [FL];
  int   arr_im [FL];
  int   arr_cnt = 0;
  bit   arr_byp = 1'b0;
  bit   byp_mode = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int frame_done_cyc = 0;
  int rise_cyc = 0;
  bit prev_valid = 1'b0;
  bit held = 1'b0;
  int held_re, held_im, held_idx;
  int acc_cyc_q[$];
  int hs_cyc_q[$];
  int last_cyc_q[$];
  int out_re_log[$];
  int out_im_log[$];
  int out_idx_log[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Sample at arrival position g%8 of frame g/8: the bin it holds, tagged by frame.
  function automatic int sample_re(input int g);
    return br_tab[g % FL] + FL * (g / FL);
  endfunction

  // Observer: compares each handshaked output with the model, records inputs.
  always @(negedge clk) begin
    exp_t e;
    int   src;
    cyc++;
    if (!rst_n) begin
      check("reset_out_valid", out_valid, 0);
      exp_q.delete();
      arr_cnt = 0;
      held = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", out_valid, 1);
        check("stall_re", out_real, held_re);
        check("stall_im", out_img, held_im);
        check("stall_idx", out_idx, held_idx);
      end
      held = out_valid && !out_ready;
      held_re = out_real;
      held_im = out_img;
      held_idx = out_idx;
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got idx %0d re %0d, expected no output", out_idx, out_real);
        end else begin
          e = exp_q.pop_front();
          check("out_re", out_real, e.re);
          check("out_im", out_img, e.im);
          check("out_idx", out_idx, e.idx);
          check("out_last", out_last, e.last);
        end
        hs_cyc_q.push_back(cyc);
        out_re_log.push_back(out_real);
        out_im_log.push_back(out_img);
        out_idx_log.push_back(out_idx);
        if (out_last) last_cyc_q.push_back(cyc);
      end
      if (in_valid && !in_ready) stall_cnt++;
      if (in_valid && in_ready) begin
`ifdef FFT_REORDER_BYPASS_EN
        if (arr_cnt == 0) arr_byp = bypass;
`else
        arr_byp = 1'b0;
`endif
        arr_re[arr_cnt] = in_real;
        arr_im[arr_cnt] = in_img;
        arr_cnt++;
        acc_cyc_q.push_back(cyc);
        if (arr_cnt == FL) begin
          for (int j = 0; j < FL; j++) begin
            src = arr_byp ? j : br_tab[j];
            e.re = arr_re[src];
            e.im = arr_im[src];
            e.idx = j;
            e.last = (j == FL - 1);
            exp_q.push_back(e);
          end
          arr_cnt = 0;
          frame_done_cyc = cyc;
        end
      end
    end
  end

  task automatic drive_samples(input int base, input int count, input bit rnd,
                               input int budget, output int cycles);
    int  k = 0;
    int  t = 0;
    bit  acc;
    while (k < count && t < budget) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_real = 16'(sample_re(base + k));
      in_img = 16'(-sample_re(base + k));
`ifdef FFT_REORDER_BYPASS_EN
      bypass = ((base + k) % FL == 0) ? byp_mode : ~byp_mode;
`endif
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      t++;
    end
    in_valid = 1'b0;
    cycles = t;
    check("drive_accepted", k, count);
  endtask

  task automatic wait_drain(input bit rnd, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < budget) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    out_ready = 1'b1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clear_logs();
    hs_cyc_q.delete();
    last_cyc_q.delete();
    out_re_log.delete();
    out_im_log.delete();
    out_idx_log.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int lsz;
    int asz;
    int byp_exp [FL];
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_real = '0;
    in_img = '0;
`ifdef FFT_REORDER_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_real", out_real, 0);
    check("rst_out_img", out_img, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);

    // Single frame, sink always ready
    out_ready = 1'b1;
    clear_logs();
    drive_samples(0, 8, 1'b0, 20, c);
    check("t1_accept_cycles", c, 8);
    wait_drain(1'b0, 40);
    check("t1_out_count", out_re_log.size(), 8);
    for (int j = 0; j < out_re_log.size(); j++) begin
      check("t1_re", out_re_log[j], j);
      check("t1_im", out_im_log[j], -j);
      check("t1_idx", out_idx_log[j], j);
    end
    check("t1_latency", rise_cyc - frame_done_cyc, 2);
    check("t1_last_count", last_cyc_q.size(), 1);

    // Streaming: four frames back-to-back
    clear_logs();
    stall_cnt = 0;
    drive_samples(8, 32, 1'b0, 64, c);
    check("t2_accept_cycles", c, 32);
    check("t2_in_stalls", stall_cnt, 0);
    wait_drain(1'b0, 60);
    check("t2_out_count", hs_cyc_q.size(), 32);
    if (hs_cyc_q.size() == 32) check("t2_out_span", hs_cyc_q[31] - hs_cyc_q[0], 31);
    else check("t2_out_span_count", hs_cyc_q.size(), 32);

    // Back-pressure: both banks fill, 17th sample stalls
    clear_logs();
    out_ready = 1'b0;
    drive_samples(40, 16, 1'b0, 40, c);
    check("t3_accept_cycles", c, 16);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_out_valid", out_valid, 1);
    check("t3_out_idx", out_idx, 0);
    check("t3_out_re", out_real, 40);
    check("t3_out_im", out_img, -40);
    stall_cnt = 0;
    asz = acc_cyc_q.size();
    in_valid = 1'b1;
    in_real = 16'(sample_re(56));
    in_img = 16'(-sample_re(56));
    repeat (4) @(posedge clk);
    #1;
    check("t3_stall_cycles", stall_cnt, 4);
    check("t3_no_accept", acc_cyc_q.size(), asz);
    lsz = last_cyc_q.size();
    out_ready = 1'b1;
    drive_samples(56, 8, 1'b0, 40, c);
    if (acc_cyc_q.size() > asz && last_cyc_q.size() > lsz)
      check("t3_resume_cycle", acc_cyc_q[asz], last_cyc_q[lsz]);
    else
      check("t3_resume_seen", acc_cyc_q.size() - asz, 8);
    wait_drain(1'b0, 60);
    check("t3_out_count", out_re_log.size(), 24);

    // Random valid/ready over 20 frames
    clear_logs();
    drive_samples(64, 160, 1'b1, 2000, c);
    wait_drain(1'b1, 2000);
    check("t4_out_count", hs_cyc_q.size(), 160);
    check("t4_partial", arr_cnt, 0);

    // Reset mid-frame discards the partial frame
    out_ready = 1'b1;
    drive_samples(0, 5, 1'b0, 20, c);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_in_reset_valid", out_valid, 0);
    rst_n = 1'b1;
    check("t5_in_ready", in_ready, 1);
    clear_logs();
    drive_samples(0, 8, 1'b0, 20, c);
    wait_drain(1'b0, 40);
    check("t5_out_count", out_re_log.size(), 8);
    for (int j = 0; j < out_re_log.size(); j++) begin
      check("t5_re", out_re_log[j], j);
      check("t5_im", out_im_log[j], -j);
    end

`ifdef FFT_REORDER_BYPASS_EN
    // Bypassed frame keeps arrival order, next frame reorders
    byp_exp = '{0, 4, 2, 6, 1, 5, 3, 7};
    clear_logs();
    byp_mode = 1'b1;
    drive_samples(0, 8, 1'b0, 20, c);
    byp_mode = 1'b0;
    drive_samples(8, 8, 1'b0, 20, c);
    wait_drain(1'b0, 60);
    check("t6_out_count", out_re_log.size(), 16);
    for (int j = 0; j < out_re_log.size(); j++) begin
      if (j < FL) check("t6_byp_re", out_re_log[j], byp_exp[j]);
      else check("t6_norm_re", out_re_log[j], j);
      check("t6_idx", out_idx_log[j], j % FL);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
